// File: rtl/imem_loader.sv
// UART boot loader: receives 8N1 bytes, packs them little-endian into 32-bit
// words and writes N_WORDS words into instruction memory while holding the
// CPU in reset. Releases the CPU once the last word has been written.
module imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int N_WORDS      = 64,
    parameter int AW           = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_rst,
    output logic          done,
    output logic          frame_err
);

    localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam int TW   = $clog2(CLKS_PER_BIT + 1);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [AW-1:0] LAST_WORD = AW'(N_WORDS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          rx_meta_q, rx_sync_q;
    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [23:0]   word_q;
    logic [1:0]    byte_cnt_q;
    logic [AW-1:0] widx_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          done_q;
    logic          ferr_q;

    logic          stop_sample;
    logic          byte_ok;

    // Stop bit is sampled on the last timer tick of STOP; a high stop bit
    // completes a valid byte on this very edge.
    assign stop_sample = (state_q == STOP) && (timer_q == BIT_LAST);
    assign byte_ok     = stop_sample && rx_sync_q;

    // Two-flop synchronizer for the asynchronous line, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver FSM: start-bit qualification at half a bit, then mid-bit sampling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (!rx_sync_q) state_q <= START;
                end
                START: begin
                    if (timer_q == HALF_LAST) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync_q ? IDLE : DATA;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                DATA: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q            <= '0;
                        shift_q[bit_idx_q] <= rx_sync_q;
                        bit_idx_q          <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) state_q <= STOP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                STOP: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky framing error: any low stop bit, including bytes after done.
    always_ff @(posedge clk) begin
        if (rst) ferr_q <= 1'b0;
        else if (stop_sample && !rx_sync_q) ferr_q <= 1'b1;
    end

    // Word assembly and memory write; the address advances while the strobe is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q <= '0;
            widx_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                widx_q <= widx_q + 1'b1;
                if (widx_q == LAST_WORD) done_q <= 1'b1;
            end
            if (byte_ok && !done_q) begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
                case (byte_cnt_q)
                    2'd0: word_q[7:0]   <= shift_q;
                    2'd1: word_q[15:8]  <= shift_q;
                    2'd2: word_q[23:16] <= shift_q;
                    default: begin
                        we_q    <= 1'b1;
                        addr_q  <= widx_q;
                        wdata_q <= {shift_q, word_q};
                    end
                endcase
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign cpu_rst    = ~done_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with 4 clocks per bit and a two-word image.
module tb_imem_loader;

    localparam int CPB = 4;
    localparam int NW  = 2;
    localparam int AW  = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitor state
    int          pulses    = 0;
    int          we_cycles = 0;
    logic        we_prev   = 1'b0;
    logic [31:0] last_addr  = '0;
    logic [31:0] last_wdata = '0;

    imem_loader #(.CLKS_PER_BIT(CPB), .N_WORDS(NW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Record write pulses away from the active edge.
    always @(negedge clk) begin
        if (imem_we) begin
            we_cycles = we_cycles + 1;
            if (!we_prev) begin
                pulses     = pulses + 1;
                last_addr  = 32'(imem_addr);
                last_wdata = imem_wdata;
            end
        end
        we_prev = imem_we;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic put_bit(input logic b);
        rx = b;
        idle(CPB);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        put_bit(1'b0);
        for (int i = 0; i < 8; i++) put_bit(d[i]);
        put_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);
    endtask

    int base;

    initial begin
        // Reset state
        idle(3);
        check("rst_we",    32'(imem_we),    32'd0);
        check("rst_addr",  32'(imem_addr),  32'd0);
        check("rst_wdata", imem_wdata,      32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_cpu",   32'(cpu_rst),    32'd1);
        check("rst_ferr",  32'(frame_err),  32'd0);
        rst = 1'b0;
        idle(4);

        // First word, frames back to back
        base = pulses;
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(12);
        check("w0_pulses", 32'(pulses - base), 32'd1);
        check("w0_addr",   last_addr,          32'd0);
        check("w0_wdata",  last_wdata,         32'h00100513);
        check("w0_done",   32'(done),          32'd0);
        check("w0_cpu",    32'(cpu_rst),       32'd1);
        check("w0_hold_a", 32'(imem_addr),     32'd0);
        check("w0_hold_d", imem_wdata,         32'h00100513);

        // Second word finishes loading
        send_byte(8'h93, 1'b1);
        send_byte(8'h85, 1'b1);
        send_byte(8'h15, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(12);
        check("w1_pulses", 32'(pulses - base), 32'd2);
        check("w1_addr",   last_addr,          32'd1);
        check("w1_wdata",  last_wdata,         32'h00158593);
        check("w1_done",   32'(done),          32'd1);
        check("w1_cpu",    32'(cpu_rst),       32'd0);
        check("w_width",   32'(we_cycles),     32'(pulses));

        // Bytes after done are ignored
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        idle(12);
        check("post_pulses", 32'(pulses - base), 32'd2);
        check("post_addr",   32'(imem_addr),     32'd1);
        check("post_wdata",  imem_wdata,         32'h00158593);
        check("post_done",   32'(done),          32'd1);

        // Glitch, then a framing error, then a clean word
        do_reset();
        check("rr_done", 32'(done),    32'd0);
        check("rr_cpu",  32'(cpu_rst), 32'd1);
        base = pulses;
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        idle(20);
        check("gl_ferr",   32'(frame_err),     32'd0);
        check("gl_pulses", 32'(pulses - base), 32'd0);
        send_byte(8'hFF, 1'b0);
        idle(12);
        check("fe_ferr", 32'(frame_err), 32'd1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle(12);
        check("fe_pulses", 32'(pulses - base), 32'd1);
        check("fe_addr",   last_addr,          32'd0);
        check("fe_wdata",  last_wdata,         32'h44332211);
        check("fe_sticky", 32'(frame_err),     32'd1);

        // Reset in the middle of a word and a frame
        do_reset();
        check("r2_ferr", 32'(frame_err), 32'd0);
        base = pulses;
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        rx = 1'b0;
        idle(CPB + 2);
        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(CPB * 12);
        check("mr_pulses", 32'(pulses - base), 32'd0);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        idle(12);
        check("mr_pulse2", 32'(pulses - base), 32'd1);
        check("mr_addr",   last_addr,          32'd0);
        check("mr_wdata",  last_wdata,         32'hEFBEADDE);
        check("mr_ferr",   32'(frame_err),     32'd0);
        check("mr_done",   32'(done),          32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
